// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment display blocks.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Nibble -> active-low segment pattern: 0-9, then A, b, C, d, E, F
    localparam logic [6:0] GLYPH_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational nibble-to-segment lookup shared by display blocks.
module seg7_glyph_rom (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    import seg7_pkg::*;

    // Pure table lookup; every nibble value has a glyph
    always_comb begin
        seg = GLYPH_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Inputs are snapshotted once per frame; each digit slot opens with an
// all-off guard interval. Define SEG7_LZB_EN to enable leading-zero
// blanking of digits 3 and 1 (the leading digit of each stopwatch half).
module seg7_scan_driver #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned SCAN_HZ = 1000,
    parameter int unsigned GUARD   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] x,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blank,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_tick
);
    import seg7_pkg::*;

    localparam int unsigned DIV = CLK_HZ / (SCAN_HZ * 4);
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] GUARD_P    = PW'(GUARD);

    if (DIV < GUARD + 2) begin : g_div_check
        $error("seg7_scan_driver: DIV (%0d) must be >= GUARD+2 (%0d)", DIV, GUARD + 2);
    end

    logic [PW-1:0] presc_q, presc_d;
    digit_idx_t    digit_q, digit_d;
    logic          first_q, first_d;
    logic [15:0]   x_s_q, x_s_d;
    logic [3:0]    dp_mask_s_q, dp_mask_s_d;
    logic [3:0]    blank_s_q, blank_s_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;
    logic          frame_tick_q, frame_tick_d;

    logic          snap_en;
    logic [3:0]    nibble;
    logic [6:0]    glyph;
    logic          auto_blank;
    logic          dark;

    seg7_glyph_rom u_glyph_rom (
        .nibble (nibble),
        .seg    (glyph)
    );

    // Slot timing, frame snapshot and frame_tick
    always_comb begin
        snap_en      = first_q || (presc_q == PRESC_LAST && digit_q == 2'd3);
        presc_d      = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        digit_d      = (presc_q == PRESC_LAST) ? digit_q + 2'd1 : digit_q;
        first_d      = 1'b0;
        x_s_d        = snap_en ? x       : x_s_q;
        dp_mask_s_d  = snap_en ? dp_mask : dp_mask_s_q;
        blank_s_d    = snap_en ? blank   : blank_s_q;
        frame_tick_d = snap_en;
    end

    // Next pin values from the current slot position and the frame snapshot
    always_comb begin
        nibble = x_s_q[{digit_q, 2'b00} +: 4];
`ifdef SEG7_LZB_EN
        auto_blank = (digit_q == 2'd3 && x_s_q[15:12] == 4'h0) ||
                     (digit_q == 2'd1 && x_s_q[7:4]   == 4'h0);
`else
        auto_blank = 1'b0;
`endif
        dark = (presc_q < GUARD_P) || blank_s_q[digit_q] || auto_blank;
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (!dark) begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = glyph;
            dp_d  = ~dp_mask_s_q[digit_q];
        end
    end

    // State and output registers; reset darkens the display immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            digit_q      <= '0;
            first_q      <= 1'b1;
            x_s_q        <= '0;
            dp_mask_s_q  <= '0;
            blank_s_q    <= '0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            digit_q      <= digit_d;
            first_q      <= first_d;
            x_s_q        <= x_s_d;
            dp_mask_s_q  <= dp_mask_s_d;
            blank_s_q    <= blank_s_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with DIV=10, GUARD=2 (40-cycle frame).
module tb_seg7_scan_driver;

    localparam int unsigned T_DIV   = 10;
    localparam int unsigned T_GUARD = 2;
    localparam int unsigned T_FRAME = 4 * T_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] x;
    logic [3:0]  dp_mask;
    logic [3:0]  blank;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        frame_tick;

    seg7_scan_driver #(
        .CLK_HZ  (400),
        .SCAN_HZ (10),
        .GUARD   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .dp_mask    (dp_mask),
        .blank      (blank),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned k;
    int          last_tick;
    logic [15:0] m_x;
    logic [3:0]  m_dpm;
    logic [3:0]  m_blk;
    logic [6:0]  obs [4];
    logic [6:0]  ref_glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t k=%0d)", tag, got, exp, $time, k);
        end
    endtask

    // Expected pins produced from slot position s (0..39) of the frame
    function automatic exp_t model_out(input int unsigned s);
        exp_t        e;
        int unsigned pr;
        int unsigned d;
        logic [3:0]  nib;
        logic        dark;
        pr   = s % T_DIV;
        d    = s / T_DIV;
        nib  = m_x[d*4 +: 4];
        dark = (pr < T_GUARD) || m_blk[d];
`ifdef SEG7_LZB_EN
        if ((d == 3 && m_x[15:12] == 4'h0) || (d == 1 && m_x[7:4] == 4'h0)) dark = 1'b1;
`endif
        e.tick = 1'b0;
        if (dark) begin
            e.an  = 4'hF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end else begin
            e.an    = 4'hF;
            e.an[d] = 1'b0;
            e.seg   = ref_glyph[nib];
            e.dp    = ~m_dpm[d];
        end
        return e;
    endfunction

    // Expectation for the pins after the next clock edge
    task automatic push_next();
        exp_t e;
        e      = model_out(k % T_FRAME);
        e.tick = (k == 0) || ((k + 1) % T_FRAME == 0);
        sb_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        k++;
        if (k == 1 || k % T_FRAME == 0) begin
            m_x   = x;
            m_dpm = dp_mask;
            m_blk = blank;
        end
        push_next();
        #1;
        e = sb_q.pop_front();
        chk("an",   32'(an),         32'(e.an));
        chk("seg",  32'(seg),        32'(e.seg));
        chk("dp",   32'(dp),         32'(e.dp));
        chk("tick", 32'(frame_tick), 32'(e.tick));
        chk("an_legal", 32'(an == 4'hF || $countones(~an) == 1), 32'd1);
        case (an)
            4'b1110: obs[0] = seg;
            4'b1101: obs[1] = seg;
            4'b1011: obs[2] = seg;
            4'b0111: obs[3] = seg;
            default: ;
        endcase
        if (frame_tick) begin
            if (last_tick >= int'(T_FRAME)) chk("tick_period", 32'(int'(k) - last_tick), 32'(T_FRAME));
            last_tick = int'(k);
        end
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int unsigned target);
        for (int unsigned i = 0; i < T_FRAME; i++) begin
            if (k % T_FRAME == target) break;
            step();
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 4; i++) obs[i] = 7'h7F;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        m_x = '0;
        m_dpm = '0;
        m_blk = '0;
        last_tick = -1;
        sb_q.delete();
        push_next();
    endtask

    initial begin
        int unsigned first_k;
        logic [3:0]  first_an;

        reset   = 1'b1;
        x       = 16'h1234;
        dp_mask = 4'b0100;
        blank   = 4'b0000;
        #2;
        chk("rst_an",   32'(an),         32'hF);
        chk("rst_seg",  32'(seg),        32'h7F);
        chk("rst_dp",   32'(dp),         32'd1);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        @(negedge clk);
        release_reset();

        // Static value
        clear_obs();
        steps(T_FRAME);
        chk("static_d0", 32'(obs[0]), 32'(ref_glyph[4]));
        chk("static_d1", 32'(obs[1]), 32'(ref_glyph[3]));
        chk("static_d2", 32'(obs[2]), 32'(ref_glyph[2]));
        chk("static_d3", 32'(obs[3]), 32'(ref_glyph[1]));

        // Tearing: change x while slot 1 is being shown
        clear_obs();
        run_to(15);
        x = 16'h5678;
        run_to(0);
        chk("tear_d0", 32'(obs[0]), 32'(ref_glyph[4]));
        chk("tear_d1", 32'(obs[1]), 32'(ref_glyph[3]));
        chk("tear_d2", 32'(obs[2]), 32'(ref_glyph[2]));
        chk("tear_d3", 32'(obs[3]), 32'(ref_glyph[1]));
        clear_obs();
        steps(T_FRAME);
        chk("new_d0", 32'(obs[0]), 32'(ref_glyph[8]));
        chk("new_d1", 32'(obs[1]), 32'(ref_glyph[7]));
        chk("new_d2", 32'(obs[2]), 32'(ref_glyph[6]));
        chk("new_d3", 32'(obs[3]), 32'(ref_glyph[5]));

        // Blank and hex glyphs
        x     = 16'hABCF;
        blank = 4'b0010;
        steps(T_FRAME);
        clear_obs();
        steps(T_FRAME);
        chk("blk_d0", 32'(obs[0]), 32'(ref_glyph[15]));
        chk("blk_d1", 32'(obs[1]), 32'h7F);
        chk("blk_d2", 32'(obs[2]), 32'(ref_glyph[11]));
        chk("blk_d3", 32'(obs[3]), 32'(ref_glyph[10]));

        // Leading zeros
        x     = 16'h0907;
        blank = 4'b0000;
        steps(T_FRAME);
        clear_obs();
        steps(T_FRAME);
        chk("lzb_d0", 32'(obs[0]), 32'(ref_glyph[7]));
        chk("lzb_d2", 32'(obs[2]), 32'(ref_glyph[9]));
`ifdef SEG7_LZB_EN
        chk("lzb_d1", 32'(obs[1]), 32'h7F);
        chk("lzb_d3", 32'(obs[3]), 32'h7F);
`else
        chk("lzb_d1", 32'(obs[1]), 32'(ref_glyph[0]));
        chk("lzb_d3", 32'(obs[3]), 32'(ref_glyph[0]));
`endif

        // Reset asynchronously at digit 2, prescaler 5
        x = 16'h1234;
        run_to(25);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_an",   32'(an),         32'hF);
        chk("mid_rst_seg",  32'(seg),        32'h7F);
        chk("mid_rst_dp",   32'(dp),         32'd1);
        chk("mid_rst_tick", 32'(frame_tick), 32'd0);
        @(negedge clk);
        @(negedge clk);
        release_reset();
        first_k  = 0;
        first_an = 4'hF;
        for (int unsigned i = 0; i < 12; i++) begin
            step();
            if (first_k == 0 && an != 4'hF) begin
                first_k  = k;
                first_an = an;
            end
        end
        chk("restart_an",    32'(first_an), 32'b1110);
        chk("restart_cycle", 32'(first_k),  32'(T_GUARD + 1));
        steps(2 * T_FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
